// File: rtl/mult_pipe.sv
// mult_pipe: elastic NUM_STAGE-deep iterative multiplier with ROB-distance squash.
// Optional feature: define MULT_UMULH_EN to widen the accumulator and honour in_hi.
module mult_pipe #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned NUM_STAGE = 8,
    parameter int unsigned ROB_W     = 5,
    parameter int unsigned PR_W      = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_opa,
    input  logic [XLEN-1:0]  in_opb,
    input  logic             in_hi,
    input  logic [ROB_W-1:0] in_rob_idx,
    input  logic [PR_W-1:0]  in_t_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [ROB_W-1:0] out_rob_idx,
    output logic [PR_W-1:0]  out_t_idx,
    input  logic             rollback_en,
    input  logic [ROB_W-1:0] rollback_idx,
    input  logic [ROB_W-1:0] tail_idx
);

    localparam int unsigned CHUNK = XLEN / NUM_STAGE;
    localparam int unsigned LAST  = NUM_STAGE - 1;
`ifdef MULT_UMULH_EN
    localparam int unsigned ACC_W = 2 * XLEN;
`else
    localparam int unsigned ACC_W = XLEN;
`endif

    // Per-stage state; the last stage needs no remaining multiplicand/multiplier.
    logic             valid_q  [NUM_STAGE];
    logic [ROB_W-1:0] rob_q    [NUM_STAGE];
    logic [PR_W-1:0]  t_q      [NUM_STAGE];
    logic [ACC_W-1:0] acc_q    [NUM_STAGE];
    logic [ACC_W-1:0] mcand_q  [NUM_STAGE-1];
    logic [XLEN-1:0]  mplier_q [NUM_STAGE-1];
`ifdef MULT_UMULH_EN
    logic             hi_q     [NUM_STAGE];
    logic             src_hi   [NUM_STAGE];
`endif

    logic             kill       [NUM_STAGE];
    logic             adv        [NUM_STAGE];
    logic             src_valid  [NUM_STAGE];
    logic [ROB_W-1:0] src_rob    [NUM_STAGE];
    logic [PR_W-1:0]  src_t      [NUM_STAGE];
    logic [ACC_W-1:0] src_mcand  [NUM_STAGE];
    logic [XLEN-1:0]  src_mplier [NUM_STAGE];
    logic [ACC_W-1:0] src_acc    [NUM_STAGE];
    logic [ACC_W-1:0] nxt_acc    [NUM_STAGE];

    // Younger-than-branch test by modular distance from the rollback point.
    function automatic logic squash_match(input logic [ROB_W-1:0] e,
                                          input logic [ROB_W-1:0] rb,
                                          input logic [ROB_W-1:0] tail);
        logic [ROB_W-1:0] d;
        logic [ROB_W-1:0] span;
        d    = e - rb;
        span = tail - rb;
        return (d != '0) && (d < span);
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NUM_STAGE; i++) begin
            kill[i] = rollback_en & valid_q[i]
                    & squash_match(rob_q[i], rollback_idx, tail_idx);
        end

        // Ready chain runs from the CDB grant back towards the issue port.
        adv[LAST] = ~valid_q[LAST] | out_ready;
        for (int unsigned i = 1; i < NUM_STAGE; i++) begin
            adv[LAST-i] = ~valid_q[LAST-i] | adv[LAST-i+1];
        end

        src_valid[0]  = in_valid
                      & ~(rollback_en & squash_match(in_rob_idx, rollback_idx, tail_idx));
        src_rob[0]    = in_rob_idx;
        src_t[0]      = in_t_idx;
        src_mcand[0]  = ACC_W'(in_opa);
        src_mplier[0] = in_opb;
        src_acc[0]    = '0;
`ifdef MULT_UMULH_EN
        src_hi[0]     = in_hi;
`endif
        for (int unsigned i = 1; i < NUM_STAGE; i++) begin
            src_valid[i]  = valid_q[i-1] & ~kill[i-1];
            src_rob[i]    = rob_q[i-1];
            src_t[i]      = t_q[i-1];
            src_mcand[i]  = mcand_q[i-1];
            src_mplier[i] = mplier_q[i-1];
            src_acc[i]    = acc_q[i-1];
`ifdef MULT_UMULH_EN
            src_hi[i]     = hi_q[i-1];
`endif
        end

        for (int unsigned i = 0; i < NUM_STAGE; i++) begin
            nxt_acc[i] = src_acc[i] + src_mcand[i] * ACC_W'(src_mplier[i][CHUNK-1:0]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_STAGE; i++) begin
                valid_q[i] <= 1'b0;
                rob_q[i]   <= '0;
                t_q[i]     <= '0;
                acc_q[i]   <= '0;
`ifdef MULT_UMULH_EN
                hi_q[i]    <= 1'b0;
`endif
            end
            for (int unsigned i = 0; i < LAST; i++) begin
                mcand_q[i]  <= '0;
                mplier_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_STAGE; i++) begin
                if (adv[i]) begin
                    valid_q[i] <= src_valid[i];
                    rob_q[i]   <= src_rob[i];
                    t_q[i]     <= src_t[i];
                    acc_q[i]   <= nxt_acc[i];
`ifdef MULT_UMULH_EN
                    hi_q[i]    <= src_hi[i];
`endif
                end else begin
                    valid_q[i] <= valid_q[i] & ~kill[i];
                end
            end
            for (int unsigned i = 0; i < LAST; i++) begin
                if (adv[i]) begin
                    mcand_q[i]  <= src_mcand[i] << CHUNK;
                    mplier_q[i] <= src_mplier[i] >> CHUNK;
                end
            end
        end
    end

    assign in_ready    = adv[0];
    assign out_valid   = valid_q[LAST] & ~kill[LAST];
    assign out_rob_idx = rob_q[LAST];
    assign out_t_idx   = t_q[LAST];

`ifdef MULT_UMULH_EN
    assign out_result = hi_q[LAST] ? acc_q[LAST][2*XLEN-1:XLEN] : acc_q[LAST][XLEN-1:0];
`else
    assign out_result = acc_q[LAST];

    logic unused_hi;
    assign unused_hi = in_hi;
`endif

    logic unused_mplier_tail;
    assign unused_mplier_tail = ^src_mplier[LAST][XLEN-1:CHUNK];

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: directed scenarios plus random traffic against a queue model.
// Honours MULT_UMULH_EN when the design is built with it.
module tb_mult_pipe;

    localparam int XLEN  = 64;
    localparam int NS    = 8;
    localparam int ROB_W = 5;
    localparam int PR_W  = 6;
    localparam int ROB_N = 1 << ROB_W;
`ifdef MULT_UMULH_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_opa;
    logic [XLEN-1:0]  in_opb;
    logic             in_hi;
    logic [ROB_W-1:0] in_rob_idx;
    logic [PR_W-1:0]  in_t_idx;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [ROB_W-1:0] out_rob_idx;
    logic [PR_W-1:0]  out_t_idx;
    logic             rollback_en;
    logic [ROB_W-1:0] rollback_idx;
    logic [ROB_W-1:0] tail_idx;

    mult_pipe #(.XLEN(XLEN), .NUM_STAGE(NS), .ROB_W(ROB_W), .PR_W(PR_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opa(in_opa), .in_opb(in_opb), .in_hi(in_hi),
        .in_rob_idx(in_rob_idx), .in_t_idx(in_t_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rob_idx(out_rob_idx), .out_t_idx(out_t_idx),
        .rollback_en(rollback_en), .rollback_idx(rollback_idx), .tail_idx(tail_idx)
    );

    typedef struct {
        int          rob;
        int          t;
        logic [63:0] res;
    } op_t;

    op_t exp_q[$];
    op_t got_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [63:0] ref_result(input logic [63:0] a, input logic [63:0] b,
                                               input logic hi);
        logic [127:0] p;
        logic         hi_eff;
        p      = {64'd0, a} * {64'd0, b};
        hi_eff = hi & HI_EN;
        return hi_eff ? p[127:64] : p[63:0];
    endfunction

    function automatic bit younger(input int e, input int rb, input int tl);
        int d;
        int span;
        d    = (e - rb + ROB_N) % ROB_N;
        span = (tl - rb + ROB_N) % ROB_N;
        return (d >= 1) && (d < span);
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 3))
            0:       return {$urandom, $urandom};
            1:       return 64'($urandom_range(0, 255));
            2:       return '1;
            default: return {32'd0, $urandom};
        endcase
    endfunction

    // Model: in-flight ops in issue order; squash removes younger ones, handshake pops the head.
    always @(negedge clock) begin
        if (!reset) begin
            exp_q.delete();
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd1);
        end else begin
            check("in_ready", 64'(in_ready), 64'((exp_q.size() < NS) || out_ready));
            if (rollback_en) begin
                for (int k = exp_q.size() - 1; k >= 0; k--) begin
                    if (younger(exp_q[k].rob, int'(rollback_idx), int'(tail_idx)))
                        exp_q.delete(k);
                end
            end
            if (exp_q.size() == 0) begin
                check("idle_out_valid", 64'(out_valid), 64'd0);
            end else if (out_valid) begin
                check("out_rob", 64'(out_rob_idx), 64'(exp_q[0].rob));
                check("out_t", 64'(out_t_idx), 64'(exp_q[0].t));
                check("out_result", out_result, exp_q[0].res);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    got_q.push_back('{int'(out_rob_idx), int'(out_t_idx), out_result});
                end
            end
            if (in_valid && in_ready
                && !(rollback_en && younger(int'(in_rob_idx), int'(rollback_idx), int'(tail_idx))))
                exp_q.push_back('{int'(in_rob_idx), int'(in_t_idx),
                                  ref_result(in_opa, in_opb, in_hi)});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic hi,
                         input int rob, input int t);
        in_valid   = 1'b1;
        in_opa     = a;
        in_opb     = b;
        in_hi      = hi;
        in_rob_idx = ROB_W'(rob);
        in_t_idx   = PR_W'(t);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int cycles);
        idle();
        rollback_en = 1'b0;
        out_ready   = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1);
    end

    logic [63:0] t2_a   [8];
    logic [63:0] t2_b   [8];
    logic [63:0] t2_exp [8];
    logic [63:0] sa     [10];
    logic [63:0] sb     [10];

    initial begin
        int idx;
        int drop_at;
        int rob_ctr;
        int bias;

        reset = 1'b0; in_valid = 1'b0; in_opa = '0; in_opb = '0; in_hi = 1'b0;
        in_rob_idx = '0; in_t_idx = '0; out_ready = 1'b1;
        rollback_en = 1'b0; rollback_idx = '0; tail_idx = '0;

        // Reset state
        tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_result", out_result, 64'd0);
        check("rst_rob", 64'(out_rob_idx), 64'd0);
        check("rst_t", 64'(out_t_idx), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // Single op latency
        for (int c = 0; c < 12; c++) begin
            if (c == 0) issue(64'd3, 64'd7, 1'b0, 2, 9); else idle();
            @(negedge clock);
            if (c == NS) begin
                check("t1_valid", 64'(out_valid), 64'd1);
                check("t1_result", out_result, 64'd21);
                check("t1_rob", 64'(out_rob_idx), 64'd2);
                check("t1_t", 64'(out_t_idx), 64'd9);
            end else begin
                check("t1_quiet", 64'(out_valid), 64'd0);
            end
            tick();
        end

        // Back-to-back
        t2_a = '{64'd1, 64'd64, 64'd5, 64'd12, 64'd57, 64'd2, 64'd24, 64'hFFFF_FFFF_FFFF_FFFF};
        t2_b = '{64'd2, 64'd2, 64'd66, 64'd14, 64'd89, 64'd33, 64'd75, 64'd2};
        t2_exp = '{64'd2, 64'd128, 64'd330, 64'd168, 64'd5073, 64'd66, 64'd1800,
                   64'hFFFF_FFFF_FFFF_FFFE};
        for (int c = 0; c < 18; c++) begin
            if (c < 8) issue(t2_a[c], t2_b[c], 1'b0, c, 30 + c); else idle();
            @(negedge clock);
            if (c >= NS && c < NS + 8) begin
                check("t2_valid", 64'(out_valid), 64'd1);
                check("t2_result", out_result, t2_exp[c-NS]);
            end else begin
                check("t2_quiet", 64'(out_valid), 64'd0);
            end
            tick();
        end

        // Stall with 10 ops, then drain
        got_q.delete();
        for (int k = 0; k < 10; k++) begin
            sa[k] = rand64();
            sb[k] = rand64();
        end
        out_ready = 1'b0;
        idx = 0;
        drop_at = -1;
        for (int c = 0; c < 14; c++) begin
            if (idx < 10) issue(sa[idx], sb[idx], 1'b0, idx, 20 + idx); else idle();
            @(negedge clock);
            if (!in_ready && drop_at < 0) drop_at = idx;
            if (c >= NS) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_rob", 64'(out_rob_idx), 64'd0);
                check("stall_result", out_result, ref_result(sa[0], sb[0], 1'b0));
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        check("stall_accepts", 64'(drop_at), 64'd8);
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (idx < 10) issue(sa[idx], sb[idx], 1'b0, idx, 20 + idx); else idle();
            @(negedge clock);
            if (in_valid && in_ready) idx++;
            tick();
        end
        check("stall_count", 64'(got_q.size()), 64'd10);
        for (int k = 0; k < 10 && k < got_q.size(); k++)
            check("stall_order", 64'(got_q[k].rob), 64'(k));

        // Wrapped rollback: rob 1 also lies between branch 5 and tail 2, so only 2..5 survive
        got_q.delete();
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c < 7) issue(64'(c + 3), 64'd11, 1'b0, c + 1, c + 40); else idle();
            rollback_en  = (c == 7);
            rollback_idx = 5'd5;
            tail_idx     = 5'd2;
            @(negedge clock);
            tick();
        end
        drain(16);
        check("rb_count", 64'(got_q.size()), 64'd4);
        for (int k = 0; k < 4 && k < got_q.size(); k++)
            check("rb_survivor", 64'(got_q[k].rob), 64'(k + 2));

        // Rollback while issuing rob 6 with a rob-6 op sitting in the last stage
        got_q.delete();
        out_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c == 0) issue(64'd4, 64'd4, 1'b0, 6, 11);
            else if (c == 1) issue(64'd9, 64'd9, 1'b0, 5, 12);
            else if (c == 11) issue(64'd7, 64'd7, 1'b0, 6, 13);
            else idle();
            if (c == 11) begin
                rollback_en  = 1'b1;
                rollback_idx = 5'd5;
                tail_idx     = 5'd7;
                out_ready    = 1'b1;
            end
            @(negedge clock);
            if (c == 11) begin
                check("same_cyc_last_rob", 64'(out_rob_idx), 64'd6);
                check("same_cyc_masked", 64'(out_valid), 64'd0);
            end
            tick();
        end
        drain(16);
        check("same_cyc_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) begin
            check("same_cyc_rob", 64'(got_q[0].rob), 64'd5);
            check("same_cyc_result", got_q[0].res, 64'd81);
        end

        // Upper-half requests
        got_q.delete();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) issue(64'h8000_0000_0000_0000, 64'd4, 1'b1, 10, 1);
            else issue('1, '1, (c == 1), 10 + c, 1 + c);
            @(negedge clock);
            tick();
        end
        drain(14);
        check("hi_count", 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
`ifdef MULT_UMULH_EN
            check("hi_pow2", got_q[0].res, 64'd2);
            check("hi_ones", got_q[1].res, 64'hFFFF_FFFF_FFFF_FFFE);
`else
            check("hi_pow2", got_q[0].res, 64'd0);
            check("hi_ones", got_q[1].res, 64'd1);
`endif
            check("lo_ones", got_q[2].res, 64'd1);
        end

        // Random traffic
        rob_ctr = 0;
        bias = 6;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) bias = $urandom_range(1, 9);
            if ($urandom_range(0, 9) < 7)
                issue(rand64(), rand64(), 1'($urandom_range(0, 1)), rob_ctr, $urandom_range(0, 63));
            else idle();
            out_ready    = ($urandom_range(0, 9) < bias);
            rollback_en  = ($urandom_range(0, 15) == 0);
            rollback_idx = ROB_W'($urandom);
            tail_idx     = ROB_W'($urandom);
            @(negedge clock);
            if (in_valid && in_ready) rob_ctr = (rob_ctr + 1) % ROB_N;
            tick();
        end
        drain(20);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset mid-flight
        for (int c = 0; c < 4; c++) begin
            if (c < 3) issue(64'(c + 100), 64'd3, 1'b0, c, c); else idle();
            @(negedge clock);
            tick();
        end
        #2 reset = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_ready", 64'(in_ready), 64'd1);
        check("arst_result", out_result, 64'd0);
        check("arst_rob", 64'(out_rob_idx), 64'd0);
        check("arst_t", 64'(out_t_idx), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            check("arst_quiet", 64'(out_valid), 64'd0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
